// File: rtl/m_data_arbiter_pkg.sv
// Shared constants and types for the gigex data-stream arbiter.
package m_data_arbiter_pkg;

   // Number of frontend modules feeding the gigex data stream
   localparam int NMODULES  = 4;
   // Data word width
   localparam int LENGTH    = 128;
   // Default words per grant before the grant rotates
   localparam int MAX_BURST = 16;
   // Width of a module index
   localparam int SRC_W     = $clog2(NMODULES);
   // Width of the per-grant word counter (MAX_BURST is at most 255)
   localparam int BURST_W   = 8;

   // Flag bit positions inside a data word
   localparam int SGL_FLAG_OFS = LENGTH - 1;
   localparam int CMD_FLAG_OFS = LENGTH - 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Index following idx, wrapping n-1 back to 0
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/m_data_arbiter_rr_picker.sv
// Round-robin search: first set bit of req at or above ptr, wrapping to 0.
module m_data_arbiter_rr_picker
   import m_data_arbiter_pkg::*;
#(
   parameter int N     = NMODULES,
   parameter int IDX_W = SRC_W
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   // rot[k] is the request of module (ptr + k) mod N
   logic [N-1:0]     rot;
   logic [IDX_W-1:0] cand_idx [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rot
         logic [IDX_W:0] sum;
         // ptr < N and gi < N, so a single subtraction completes the modulo
         assign sum          = {1'b0, ptr_i} + (IDX_W+1)'(gi);
         assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                       : IDX_W'(sum);
         assign rot[gi]      = req_i[cand_idx[gi]];
      end
   endgenerate

   // Lowest rotated position wins; scanning downward lets it overwrite higher ones
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found_o = 1'b1;
            idx_o   = cand_idx[k];
         end
      end
   end

endmodule

// File: rtl/m_data_arbiter.sv
// Round-robin arbiter sharing the gigex data stream between the per-module rx fifos.
// Holds a grant for at most MAX_BURST words and registers the outgoing word.
module m_data_arbiter #(
   parameter int  NMODULES  = m_data_arbiter_pkg::NMODULES,
   parameter int  LENGTH    = m_data_arbiter_pkg::LENGTH,
   parameter int  MAX_BURST = m_data_arbiter_pkg::MAX_BURST,
   localparam int SRC_W     = $clog2(NMODULES)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NMODULES-1:0]        en_mask_i,
   input  logic [NMODULES-1:0]        in_valid_i,
   output logic [NMODULES-1:0]        in_ready_o,
   input  logic [NMODULES*LENGTH-1:0] in_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [LENGTH-1:0]          out_data_o,
   output logic [SRC_W-1:0]           out_src_o,
   output logic                       busy_o
);

   import m_data_arbiter_pkg::*;

   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
   localparam logic [SRC_W-1:0]   SRC_LAST   = SRC_W'(NMODULES - 1);

   arb_state_e          state_q, state_d;
   logic [SRC_W-1:0]    ptr_q, ptr_d;
   logic [SRC_W-1:0]    sel_q, sel_d;
   logic [BURST_W-1:0]  burst_q, burst_d;
   logic                out_valid_q, out_valid_d;
   logic [LENGTH-1:0]   out_data_q, out_data_d;
   logic [SRC_W-1:0]    out_src_q, out_src_d;

   logic [NMODULES-1:0] req;
   logic                pick_found;
   logic [SRC_W-1:0]    pick_idx;
   logic                sel_ok;
   logic                load;
   logic                xfer;
   logic [SRC_W-1:0]    sel_next;
   logic [LENGTH-1:0]   in_word [NMODULES];

   genvar gi;
   generate
      for (gi = 0; gi < NMODULES; gi++) begin : g_word
         assign in_word[gi] = in_data_i[gi*LENGTH +: LENGTH];
      end
   endgenerate

   assign req      = in_valid_i & en_mask_i;
   assign sel_ok   = in_valid_i[sel_q] & en_mask_i[sel_q];
   // Output register can take a word when empty or being drained this cycle
   assign load     = ~out_valid_q | out_ready_i;
   assign xfer     = (state_q == GRANT) & load & sel_ok;
   assign sel_next = (sel_q == SRC_LAST) ? '0 : sel_q + SRC_W'(1);

   m_data_arbiter_rr_picker #(
      .N     (NMODULES),
      .IDX_W (SRC_W)
   ) u_picker (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Pop strobe goes only to the granted module, only on a transfer
   always_comb begin
      in_ready_o = '0;
      if (xfer) begin
         in_ready_o[sel_q] = 1'b1;
      end
   end

   // Grant FSM: pick in IDLE, stream in GRANT until burst limit or the grantee drops
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      burst_d = burst_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               burst_d = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               burst_d = burst_q + BURST_W'(1);
               if (burst_q == BURST_LAST) begin
                  state_d = IDLE;
                  ptr_d   = sel_next;
               end
            end else if (!sel_ok) begin
               state_d = IDLE;
               ptr_d   = sel_next;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register: load on transfer, clear valid once the word is taken
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_word[sel_q];
         out_src_d   = sel_q;
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any word held for gigex
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         burst_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         burst_q     <= burst_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_src_o   = out_src_q;
   assign busy_o      = (state_q == GRANT);

endmodule
